muldiv_unit: RTL and testbench

- Multi-cycle signed multiply/divide/modulo engine for the ConfusedCore HMMM datapath.
- Executes HMMM mul, div and mod, which the single-cycle add/sub ALU does not implement.
- The control unit issues an operation with a start pulse and stalls on busy. It writes result back to rX when done pulses.
- Fixed-latency shift-add multiplier and restoring divider working on operand magnitudes, followed by a sign-fix step.

---
 rtl/muldiv_unit.sv | 121 ++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide/modulo engine for the HMMM datapath.
// Shift-add multiplier and restoring divider run on operand magnitudes, then a sign-fix step.
module muldiv_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] work_a, work_b, acc;
  logic [CW-1:0]    counter;

  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] fix_result;
  logic             fix_dbz;

  // work_a holds the multiplier (mul) or dividend shifting into quotient (div/mod);
  // acc holds the running product or partial remainder.
  always_comb begin
    shifted = {acc, work_a[WIDTH-1]};
    diff    = shifted - {1'b0, work_b};
  end

  always_comb begin
    fix_result = '0;
    fix_dbz    = 1'b0;
    case (op_r)
      2'b00: fix_result = (sign_a ^ sign_b) ? -acc : acc;
      2'b01: begin
        if (b_r == '0) fix_dbz = 1'b1;
        else           fix_result = (sign_a ^ sign_b) ? -work_a : work_a;
      end
      2'b10: begin
        if (b_r == '0) fix_dbz = 1'b1;
        else           fix_result = sign_a ? -acc : acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      work_a      <= '0;
      work_b      <= '0;
      acc         <= '0;
      counter     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          sign_a  <= a_r[WIDTH-1];
          sign_b  <= b_r[WIDTH-1];
          work_a  <= a_r[WIDTH-1] ? -a_r : a_r;
          work_b  <= b_r[WIDTH-1] ? -b_r : b_r;
          acc     <= '0;
          counter <= CW'(WIDTH - 1);
          state   <= ITER;
        end
        ITER: begin
          if (op_r == 2'b00) begin
            if (work_a[0]) acc <= acc + work_b;
            work_a <= work_a >> 1;
            work_b <= work_b << 1;
          end else if (!diff[WIDTH]) begin
            acc    <= diff[WIDTH-1:0];
            work_a <= {work_a[WIDTH-2:0], 1'b1};
          end else begin
            acc    <= shifted[WIDTH-1:0];
            work_a <= {work_a[WIDTH-2:0], 1'b0};
          end
          counter <= counter - CW'(1);
          if (counter == '0) state <= FIX;
        end
        FIX: begin
          result      <= fix_result;
          div_by_zero <= fix_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors from the HMMM semantics plus
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                    output logic [15:0] r, output logic dz);
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = 16'h0000;
    dz = 1'b0;
    case (o)
      2'b00: r = 16'(sx * sy);
      2'b01: if (y == 16'h0) dz = 1'b1; else r = 16'(sx / sy);
      2'b10: if (y == 16'h0) dz = 1'b1; else r = 16'(sx % sy);
      default: r = 16'h0000;
    endcase
  endfunction

  // Issues one op and returns the outcome; lat counts edges after the sampling edge (40 = timeout).
  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic dz, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    dz = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, div_by_zero} !== 19'h0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b result=%h dbz=%b, need all 0", busy, done, result, div_by_zero);
    end
  endtask

  task automatic test_directed();
    logic [15:0] r, exp_r;
    logic dz, exp_dz;
    int lat;
    logic [1:0]  ops [7]  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    logic [15:0] xs  [7]  = '{16'd7, 16'd300, 16'hFFF9, 16'hFFF9, 16'd7, 16'h8000, 16'd5};
    logic [15:0] ys  [7]  = '{16'hFFFD, 16'd300, 16'd2, 16'd2, 16'hFFFE, 16'hFFFF, 16'd0};
    logic [15:0] exps[7]  = '{16'hFFEB, 16'h5F90, 16'hFFFD, 16'hFFFF, 16'h0001, 16'h8000, 16'h0000};
    logic        expz[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], xs[i], ys[i], r, dz, lat);
      exp_r = exps[i]; exp_dz = expz[i];
      checks++;
      if (lat !== 18) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges, need 18", i, lat);
      end
      checks++;
      if (r !== exp_r || dz !== exp_dz) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h dbz=%b, need %h dbz=%b", i, r, dz, exp_r, exp_dz);
      end
    end
    do_op(2'b00, 16'd2, 16'd3, r, dz, lat);
    checks++;
    if (r !== 16'h0006 || dz !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: got %h dbz=%b, need 0006 dbz=0", r, dz);
    end
  endtask

  task automatic test_random();
    logic [15:0] r, x, y, exp_r;
    logic dz, exp_dz;
    logic [1:0] o;
    int lat;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      x = 16'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if (i % 10 == 3) x = 16'h8000;
      if (i % 10 == 4) y = 16'hFFFF;
      ref_model(o, x, y, exp_r, exp_dz);
      do_op(o, x, y, r, dz, lat);
      checks++;
      if (lat !== 18 || r !== exp_r || dz !== exp_dz) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h dbz=%b lat=%0d, need %h dbz=%b lat=18",
                 i, o, x, y, r, dz, lat, exp_r, exp_dz);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    int busy_low = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'd123; b = 16'hFF9C;   // 123 * -100
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (lat == 5) begin start = 1'b1; op = 2'b01; a = 16'd9; b = 16'd4; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_low++;
    end
    start = 1'b0;
    checks++;
    if (busy_low != 0 || lat !== 18) begin
      errors++;
      $display("FAIL ignore_busy: busy low %0d cycles, lat=%0d, need 0 and 18", busy_low, lat);
    end
    checks++;
    if (result !== 16'hCFF4) begin
      errors++;
      $display("FAIL ignore_result: got %h, need cff4", result);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic dz;
    int lat;
    do_op(2'b00, 16'd4, 16'd5, r, dz, lat);
    // do_op drives start during the current done cycle, so this is accepted with no gap
    do_op(2'b01, 16'd100, 16'd7, r, dz, lat);
    checks++;
    if (r !== 16'h000E || dz !== 1'b0 || lat !== 18) begin
      errors++;
      $display("FAIL back_to_back: got %h dbz=%b lat=%0d, need 000e dbz=0 lat=18", r, dz, lat);
    end
  endtask

  task automatic test_reset_midop();
    int late_done = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'd11; b = 16'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, result, div_by_zero} !== 19'h0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b result=%h dbz=%b, need all 0", busy, done, result, div_by_zero);
    end
    @(negedge clk) reset = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) late_done++;
    end
    checks++;
    if (late_done != 0) begin
      errors++;
      $display("FAIL reset_abandon: activity seen in %0d cycles after reset, need 0", late_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
